reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port architectural register file for the CPU core. It holds the general registers x[0..NREG-1], the program counter and the interrupt-enable flag.
- Provides NRD read ports and NWR write ports, a configurable write-to-read bypass, and an optional registered read stage.
- Keeps a per-register busy scoreboard. The issue stage sets a busy bit when it allocates a destination; writeback clears it. Decode uses the busy bits to detect hazards.

Parameters:
XLEN, 32, data width of each register and of pc
NREG, 32, number of general registers (power of two, >= 2)
NRD, 2, number of read ports
NWR, 1, number of write ports
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports
READ_LAT, 0, 0 = combinational read, 1 = registered read (one-cycle latency)
RESET_PC, 0, value loaded into pc on reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
rd_addr  in  NRD x clog2(NREG)  read addresses
rd_data  out  NRD x XLEN  read data
rd_busy  out  NRD  busy bit of the addressed register
wr_en  in  NWR  write enables
wr_addr  in  NWR x clog2(NREG)  write addresses
wr_data  in  NWR x XLEN  write data
alloc_en  in  1  mark alloc_addr busy
alloc_addr  in  clog2(NREG)  register being allocated
pc_we  in  1  pc write enable
pc_next  in  XLEN  new pc
pc  out  XLEN  current pc
intr_en_we  in  1  interrupt-enable write enable
intr_en_next  in  1  new interrupt-enable value
intr_en  out  1  current interrupt-enable

Behaviour:
- Reset: when reset_n is low, the block clears immediately, without waiting for a clock edge.
  - All x[] = 0, all busy = 0, pc = RESET_PC, intr_en = 0.
  - rd_data = 0 and rd_busy = 0 in both READ_LAT modes, including the output register when READ_LAT=1.
  - A reset asserted mid-operation discards all in-flight writes and allocations.
- x0:
  - Reads of x0 always return 0, and rd_busy for x0 is always 0.
  - Writes and allocations to address 0 are ignored.
- Write:
  - On the rising edge, x[wr_addr[i]] <= wr_data[i] for each i with wr_en[i]=1.
  - If two or more ports write the same address in one cycle, the highest-index port wins.
- Read, READ_LAT=0: rd_data[j] = x[rd_addr[j]] combinationally.
- Read, READ_LAT=1: rd_data[j] and rd_busy[j] are registered and reflect the address presented in the previous cycle.
- Bypass:
  - Applies when BYPASS=1 and some wr_en[i] has wr_addr[i] == rd_addr[j] (non-zero address) in the same cycle.
  - rd_data[j] = wr_data of the highest such i, and rd_busy[j] = 0.
  - When BYPASS=0, reads return the pre-edge value.
- Busy scoreboard, next-state rule per register r:
  - alloc_en and alloc_addr==r: set to 1.
  - Otherwise any write to r: clear to 0.
  - Otherwise: hold.
  - Simultaneous alloc and write to the same register leaves busy=1, because the allocation is newer.
  - Allocating an already-busy register keeps it busy; no error is flagged.
- pc:
  - pc <= pc_next when pc_we; otherwise pc holds.
  - pc_next is taken as-is, with no alignment enforcement.
- intr_en: intr_en <= intr_en_next when intr_en_we; otherwise it holds.
- Out-of-range addresses cannot occur because NREG is a power of two.
- Latency summary:
  - Write becomes visible without bypass on the cycle after the edge.
  - With READ_LAT=1, add one further cycle.

Test Plan:
- Reset: hold reset_n=0 mid-cycle with RESET_PC=0x100 -> pc=0x100, intr_en=0, and all rd_data/rd_busy=0 immediately, before any clock edge. Release reset, read x5 -> 0.
- Write/read, BYPASS=0, READ_LAT=0: write x3=0xDEADBEEF -> rd_data reads 0 in the same cycle and 0xDEADBEEF in the next cycle. Write x0=0x1234 -> x0 reads 0.
- Bypass and port priority, NWR=2, BYPASS=1: port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle, with rd_addr[0]=7 -> rd_data[0]=0x22 that cycle, and x7=0x22 afterwards.
- Scoreboard: alloc x9 -> rd_busy=1 next cycle. Write x9 -> busy cleared next cycle. Alloc and write x9 in the same cycle -> busy stays 1. Alloc x0 -> rd_busy stays 0.
- READ_LAT=1: present rd_addr=3 in cycle N -> rd_data is valid in cycle N+1. Change the address in cycle N+1 -> rd_data still shows the old address's value until N+2.
- pc/intr_en: pc_we with pc_next=0x40 -> pc=0x40 next cycle. With pc_we=0, pc holds. Pulse intr_en_we with value 1 -> intr_en=1, held until the next write or reset.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port architectural register file: x[0..NREG-1], pc and interrupt enable,
// with write-to-read bypass, optional registered read and a per-register busy scoreboard.
module reg_file_mp #(
   parameter int               XLEN     = 32,
   parameter int               NREG     = 32,
   parameter int               NRD      = 2,
   parameter int               NWR      = 1,
   parameter int               BYPASS   = 1,
   parameter int               READ_LAT = 0,
   parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}},
   localparam int              AW       = $clog2(NREG)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NRD-1:0][AW-1:0]    rd_addr,
   output logic [NRD-1:0][XLEN-1:0]  rd_data,
   output logic [NRD-1:0]            rd_busy,
   input  logic [NWR-1:0]            wr_en,
   input  logic [NWR-1:0][AW-1:0]    wr_addr,
   input  logic [NWR-1:0][XLEN-1:0]  wr_data,
   input  logic                      alloc_en,
   input  logic [AW-1:0]             alloc_addr,
   input  logic                      pc_we,
   input  logic [XLEN-1:0]           pc_next,
   output logic [XLEN-1:0]           pc,
   input  logic                      intr_en_we,
   input  logic                      intr_en_next,
   output logic                      intr_en
);

   localparam logic [AW-1:0] ZERO_A = {AW{1'b0}};

   logic [XLEN-1:0]            r_x [NREG];
   logic [NREG-1:0]            r_busy;
   logic [XLEN-1:0]            r_pc;
   logic                       r_intr_en;

   logic [NREG-1:0]            w_wr_hit;
   logic [NREG-1:0]            w_busy_nxt;
   logic [NRD-1:0]             w_byp_hit;
   logic [NRD-1:0][XLEN-1:0]   w_byp_data;
   logic [NRD-1:0][XLEN-1:0]   w_rd_data;
   logic [NRD-1:0]             w_rd_busy;

   // Register array update; ports are walked in ascending order so the highest port wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NREG; r++) begin
            r_x[r] <= {XLEN{1'b0}};
         end
      end else begin
         for (int i = 0; i < NWR; i++) begin
            if (wr_en[i] && (wr_addr[i] != ZERO_A)) begin
               r_x[wr_addr[i]] <= wr_data[i];
            end else begin
               r_x[0] <= {XLEN{1'b0}};
            end
         end
      end
   end

   // Which registers receive a write this cycle.
   always_comb begin
      w_wr_hit = {NREG{1'b0}};
      for (int i = 0; i < NWR; i++) begin
         w_wr_hit[wr_addr[i]] = w_wr_hit[wr_addr[i]] | wr_en[i];
      end
   end

   // Scoreboard next state: a new allocation outranks a completing write.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int r = 0; r < NREG; r++) begin
         if (alloc_en && (alloc_addr == AW'(r))) begin
            w_busy_nxt[r] = 1'b1;
         end else if (w_wr_hit[r]) begin
            w_busy_nxt[r] = 1'b0;
         end else begin
            w_busy_nxt[r] = r_busy[r];
         end
      end
      w_busy_nxt[0] = 1'b0;
   end

   // Busy bit storage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy <= {NREG{1'b0}};
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   // Read path: x0 forced to zero, otherwise the newest same-cycle write beats storage.
   always_comb begin
      w_byp_hit  = {NRD{1'b0}};
      w_byp_data = {(NRD*XLEN){1'b0}};
      w_rd_data  = {(NRD*XLEN){1'b0}};
      w_rd_busy  = {NRD{1'b0}};
      for (int j = 0; j < NRD; j++) begin
         for (int i = 0; i < NWR; i++) begin
            w_byp_data[j] = ((BYPASS != 0) && wr_en[i] && (wr_addr[i] == rd_addr[j]))
                            ? wr_data[i] : w_byp_data[j];
            w_byp_hit[j]  = w_byp_hit[j] |
                            ((BYPASS != 0) && wr_en[i] && (wr_addr[i] == rd_addr[j]));
         end
         if (rd_addr[j] == ZERO_A) begin
            w_rd_data[j] = {XLEN{1'b0}};
            w_rd_busy[j] = 1'b0;
         end else if (w_byp_hit[j]) begin
            w_rd_data[j] = w_byp_data[j];
            w_rd_busy[j] = 1'b0;
         end else begin
            w_rd_data[j] = r_x[rd_addr[j]];
            w_rd_busy[j] = r_busy[rd_addr[j]];
         end
      end
   end

   generate
      if (READ_LAT == 0) begin : g_comb_rd
         // Gate with reset so a bypassed write cannot leak out while held in reset.
         assign rd_data = reset_n ? w_rd_data : {(NRD*XLEN){1'b0}};
         assign rd_busy = reset_n ? w_rd_busy : {NRD{1'b0}};
      end else begin : g_reg_rd
         logic [NRD-1:0][XLEN-1:0] r_rd_data;
         logic [NRD-1:0]           r_rd_busy;

         // One-cycle read output stage.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_rd_data <= {(NRD*XLEN){1'b0}};
               r_rd_busy <= {NRD{1'b0}};
            end else begin
               r_rd_data <= w_rd_data;
               r_rd_busy <= w_rd_busy;
            end
         end
         assign rd_data = r_rd_data;
         assign rd_busy = r_rd_busy;
      end
   endgenerate

   // Program counter and interrupt enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc      <= RESET_PC;
         r_intr_en <= 1'b0;
      end else begin
         if (pc_we) begin
            r_pc <= pc_next;
         end else begin
            r_pc <= r_pc;
         end
         if (intr_en_we) begin
            r_intr_en <= intr_en_next;
         end else begin
            r_intr_en <= r_intr_en;
         end
      end
   end

   assign pc      = r_pc;
   assign intr_en = r_intr_en;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: three configurations share one stimulus stream;
// expectations are queued with their check cycle and a negedge monitor compares them.
module tb_reg_file_mp;

   logic clk;
   logic reset_n;
   logic [1:0][4:0]  rd_addr;
   logic [1:0]       wr_en;
   logic [1:0][4:0]  wr_addr;
   logic [1:0][31:0] wr_data;
   logic             alloc_en;
   logic [4:0]       alloc_addr;
   logic             pc_we;
   logic [31:0]      pc_next;
   logic             intr_en_we;
   logic             intr_en_next;

   logic [1:0][31:0] a_rd_data, b_rd_data, c_rd_data;
   logic [1:0]       a_rd_busy, b_rd_busy, c_rd_busy;
   logic [31:0]      a_pc, b_pc, c_pc;
   logic             a_intr, b_intr, c_intr;

   // A: two write ports with bypass, combinational read
   reg_file_mp #(.NWR(2), .BYPASS(1), .READ_LAT(0), .RESET_PC(32'h100)) dut_a (
      .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
      .alloc_addr(alloc_addr), .pc_we(pc_we), .pc_next(pc_next), .pc(a_pc),
      .intr_en_we(intr_en_we), .intr_en_next(intr_en_next), .intr_en(a_intr));

   // B: one write port, no bypass, combinational read
   reg_file_mp #(.NWR(1), .BYPASS(0), .READ_LAT(0), .RESET_PC(32'h100)) dut_b (
      .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
      .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .alloc_en(alloc_en),
      .alloc_addr(alloc_addr), .pc_we(pc_we), .pc_next(pc_next), .pc(b_pc),
      .intr_en_we(intr_en_we), .intr_en_next(intr_en_next), .intr_en(b_intr));

   // C: one write port, bypass, registered read
   reg_file_mp #(.NWR(1), .BYPASS(1), .READ_LAT(1), .RESET_PC(32'h100)) dut_c (
      .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
      .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .alloc_en(alloc_en),
      .alloc_addr(alloc_addr), .pc_we(pc_we), .pc_next(pc_next), .pc(c_pc),
      .intr_en_we(intr_en_we), .intr_en_next(intr_en_next), .intr_en(c_intr));

   typedef struct {
      int          dut;   // 0=A 1=B 2=C
      int          kind;  // 0=rd_data 1=rd_busy 2=pc 3=intr_en
      int          port;
      logic [31:0] val;
      int          when;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   int   c;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   function automatic logic [31:0] actual(input int dut, input int kind, input int port);
      logic [31:0] v;
      v = 32'hFFFF_FFFF;
      case (dut)
         0: case (kind)
               0: v = a_rd_data[port];
               1: v = {31'd0, a_rd_busy[port]};
               2: v = a_pc;
               default: v = {31'd0, a_intr};
            endcase
         1: case (kind)
               0: v = b_rd_data[port];
               1: v = {31'd0, b_rd_busy[port]};
               2: v = b_pc;
               default: v = {31'd0, b_intr};
            endcase
         default: case (kind)
               0: v = c_rd_data[port];
               1: v = {31'd0, c_rd_busy[port]};
               2: v = c_pc;
               default: v = {31'd0, c_intr};
            endcase
      endcase
      return v;
   endfunction

   // Monitor: compare every queued expectation that is due this cycle.
   initial forever begin
      @(negedge clk);
      for (int k = sb.size() - 1; k >= 0; k--) begin
         if (sb[k].when == cyc) begin
            logic [31:0] act;
            act = actual(sb[k].dut, sb[k].kind, sb[k].port);
            total = total + 1;
            if (act !== sb[k].val) begin
               bad = bad + 1;
               $display("FAIL %s (dut%0d cyc %0d): got %h want %h",
                        sb[k].name, sb[k].dut, cyc, act, sb[k].val);
            end
            sb.delete(k);
         end
      end
   end

   task automatic expect_v(input int dut, input int kind, input int port,
                           input logic [31:0] val, input int when, input string name);
      exp_t e;
      e.dut = dut; e.kind = kind; e.port = port; e.val = val; e.when = when; e.name = name;
      sb.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      c = cyc;
      wr_en      = 2'b00;
      alloc_en   = 1'b0;
      pc_we      = 1'b0;
      intr_en_we = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      rd_addr = '0; wr_en = 2'b00; wr_addr = '0; wr_data = '0;
      alloc_en = 1'b0; alloc_addr = 5'd0; pc_we = 1'b0; pc_next = 32'd0;
      intr_en_we = 1'b0; intr_en_next = 1'b0;
      @(posedge clk);

      // release reset, read x5
      next_cycle(); reset_n = 1'b1;
      rd_addr[0] = 5'd5;
      expect_v(0, 0, 0, 32'h0, c, "rst_x5_a");
      expect_v(2, 0, 0, 32'h0, c, "rst_x5_c");
      expect_v(0, 2, 0, 32'h100, c, "rst_pc");
      expect_v(0, 3, 0, 32'h0, c, "rst_intr");

      // write x3, same-cycle read
      next_cycle();
      wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'hDEADBEEF; rd_addr[0] = 5'd3;
      expect_v(1, 0, 0, 32'h0, c, "nobyp_same_cycle");
      expect_v(0, 0, 0, 32'hDEADBEEF, c, "byp_same_cycle");

      // x3 visible next cycle; write to x0 ignored
      next_cycle();
      wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'h1234; rd_addr[1] = 5'd0;
      expect_v(1, 0, 0, 32'hDEADBEEF, c, "nobyp_next_cycle");
      expect_v(1, 0, 1, 32'h0, c, "x0_write_same_b");
      expect_v(0, 0, 1, 32'h0, c, "x0_write_same_a");

      // dual-port write to x7, highest port wins
      next_cycle();
      wr_en = 2'b11; wr_addr[0] = 5'd7; wr_data[0] = 32'h11;
      wr_addr[1] = 5'd7; wr_data[1] = 32'h22; rd_addr[0] = 5'd7;
      expect_v(0, 0, 0, 32'h22, c, "byp_priority");
      expect_v(1, 0, 1, 32'h0, c, "x0_after_write");

      next_cycle();
      expect_v(0, 0, 0, 32'h22, c, "port_priority_stored");
      expect_v(1, 0, 0, 32'h11, c, "single_port_x7");

      // allocate x9
      next_cycle();
      alloc_en = 1'b1; alloc_addr = 5'd9; rd_addr[0] = 5'd9;
      expect_v(0, 1, 0, 32'h0, c, "busy_before_alloc");

      next_cycle();
      expect_v(0, 1, 0, 32'h1, c, "busy_after_alloc_a");
      expect_v(1, 1, 0, 32'h1, c, "busy_after_alloc_b");

      // writeback x9
      next_cycle();
      wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h99;
      expect_v(1, 1, 0, 32'h1, c, "busy_during_wb_nobyp");
      expect_v(0, 1, 0, 32'h0, c, "busy_during_wb_byp");

      next_cycle();
      expect_v(0, 1, 0, 32'h0, c, "busy_cleared_a");
      expect_v(1, 1, 0, 32'h0, c, "busy_cleared_b");

      // alloc and write x9 together
      next_cycle();
      alloc_en = 1'b1; alloc_addr = 5'd9;
      wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h9A;
      expect_v(1, 1, 0, 32'h0, c, "busy_pre_alloc_wr");

      next_cycle();
      expect_v(0, 1, 0, 32'h1, c, "alloc_beats_write_a");
      expect_v(1, 1, 0, 32'h1, c, "alloc_beats_write_b");
      expect_v(1, 0, 0, 32'h9A, c, "x9_data");

      // allocate x0
      next_cycle();
      alloc_en = 1'b1; alloc_addr = 5'd0; rd_addr[0] = 5'd0;
      expect_v(0, 1, 0, 32'h0, c, "alloc_x0_same");

      next_cycle();
      pc_we = 1'b1; pc_next = 32'h40; intr_en_we = 1'b1; intr_en_next = 1'b1;
      expect_v(0, 1, 0, 32'h0, c, "alloc_x0_a");
      expect_v(1, 1, 0, 32'h0, c, "alloc_x0_b");
      expect_v(0, 2, 0, 32'h100, c, "pc_before_we");
      expect_v(0, 3, 0, 32'h0, c, "intr_before_we");

      next_cycle();
      pc_next = 32'h80; intr_en_next = 1'b0;
      expect_v(0, 2, 0, 32'h40, c, "pc_written");
      expect_v(0, 3, 0, 32'h1, c, "intr_written");

      next_cycle();
      expect_v(0, 2, 0, 32'h40, c, "pc_hold");
      expect_v(1, 3, 0, 32'h1, c, "intr_hold");

      // registered read latency on C
      next_cycle();
      rd_addr[0] = 5'd3; rd_addr[1] = 5'd9;
      expect_v(2, 0, 0, 32'h0, c, "rlat_prev_addr");

      next_cycle();
      rd_addr[0] = 5'd7;
      expect_v(2, 0, 0, 32'hDEADBEEF, c, "rlat_n_plus_1");
      expect_v(2, 1, 1, 32'h1, c, "rlat_busy");

      next_cycle();
      expect_v(2, 0, 0, 32'h11, c, "rlat_n_plus_2");

      // mid-cycle reset with an in-flight write
      next_cycle();
      reset_n = 1'b0;
      wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h55; rd_addr[0] = 5'd3;
      expect_v(0, 2, 0, 32'h100, c, "async_rst_pc");
      expect_v(0, 3, 0, 32'h0, c, "async_rst_intr");
      expect_v(0, 0, 0, 32'h0, c, "async_rst_rd_a");
      expect_v(0, 1, 1, 32'h0, c, "async_rst_busy_a");
      expect_v(1, 0, 0, 32'h0, c, "async_rst_rd_b");
      expect_v(2, 0, 0, 32'h0, c, "async_rst_rd_c");
      expect_v(2, 1, 1, 32'h0, c, "async_rst_busy_c");

      #1;
      total = total + 1;
      if (a_pc !== 32'h100) begin
         bad = bad + 1;
         $display("FAIL imm_rst_pc: got %h want %h", a_pc, 32'h100);
      end
      total = total + 1;
      if (a_intr !== 1'b0) begin
         bad = bad + 1;
         $display("FAIL imm_rst_intr: got %b want 0", a_intr);
      end
      total = total + 1;
      if (a_rd_data[0] !== 32'h0) begin
         bad = bad + 1;
         $display("FAIL imm_rst_rd_a: got %h want 0", a_rd_data[0]);
      end
      total = total + 1;
      if (b_rd_data[0] !== 32'h0) begin
         bad = bad + 1;
         $display("FAIL imm_rst_rd_b: got %h want 0", b_rd_data[0]);
      end
      total = total + 1;
      if (c_rd_data[0] !== 32'h0) begin
         bad = bad + 1;
         $display("FAIL imm_rst_rd_c: got %h want 0", c_rd_data[0]);
      end
      total = total + 1;
      if (c_rd_busy !== 2'b00) begin
         bad = bad + 1;
         $display("FAIL imm_rst_busy_c: got %b want 00", c_rd_busy);
      end

      next_cycle();
      reset_n = 1'b1;
      expect_v(1, 0, 0, 32'h0, c, "rst_discard_write");
      expect_v(0, 2, 0, 32'h100, c, "rst_pc_after");

      next_cycle();
      next_cycle();
      next_cycle();

      while (sb.size() > 0) begin
         bad = bad + 1;
         total = total + 1;
         $display("FAIL %s: got never-checked want checked at cyc %0d", sb[0].name, sb[0].when);
         void'(sb.pop_front());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
